// File: rtl/obi_mux_pkg.sv
// Constants and helpers for the N-to-1 OBI multiplexer.
package obi_mux_pkg;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;
    localparam int PERF_CNT_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by bus blocks.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_mux_idx_fifo.sv
// Synchronous FIFO holding the master index of each granted, unanswered transaction.
module obi_mux_idx_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop)  rptr <= nxt(rptr);
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata_i;
    end

endmodule

// File: rtl/obi_mux_rr_outstanding.sv
// N-to-1 OBI mux: RR/fixed arbitration, address-phase lock, in-order response routing.
// OBI_MUX_PERF_EN adds per-master handshake counters and a full-FIFO stall counter.
module obi_mux_rr_outstanding
    import obi_pkg::*;
    import obi_mux_pkg::*;
#(
    parameter int NMASTER         = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RR_MODE         = ARB_RR,
    parameter int IDX_W           = idx_width(NMASTER),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  obi_req_t  [NMASTER-1:0]  master_req_i,
    output obi_resp_t [NMASTER-1:0]  master_resp_o,
    output obi_req_t                 slave_req_o,
    input  obi_resp_t                slave_resp_i,
    output logic      [CNT_W-1:0]    outstanding_o,
    output logic                     busy_o,
    output logic                     err_o
`ifdef OBI_MUX_PERF_EN
    ,
    output logic [NMASTER-1:0][PERF_CNT_W-1:0] grant_cnt_o,
    output logic [PERF_CNT_W-1:0]              stall_cnt_o
`endif
);

    logic [NMASTER-1:0] req_vec, elig;
    logic [IDX_W-1:0]   rr_ptr, arb_idx, sel, lock_idx, head_idx;
    logic               lock_vld, any_elig, fifo_full, fifo_empty, push, pop;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NMASTER; i++) req_vec[i] = master_req_i[i].req;
    end

    assign elig     = fifo_full ? '0 : req_vec;
    assign any_elig = |elig;

    always_comb begin
        int c;
        arb_idx = '0;
        for (int k = NMASTER - 1; k >= 0; k--) begin
            c = (RR_MODE == ARB_RR) ? (int'(rr_ptr) + k) % NMASTER : k;
            if (elig[c]) arb_idx = IDX_W'(c);
        end
    end

    // A stalled address phase keeps its master until granted or until it drops req.
    assign sel = (lock_vld && elig[lock_idx]) ? lock_idx : arb_idx;

    always_comb begin
        slave_req_o     = master_req_i[sel];
        slave_req_o.req = any_elig;
    end

    assign push = slave_req_o.req & slave_resp_i.gnt;
    assign pop  = slave_resp_i.rvalid & ~fifo_empty;

    always_comb begin
        for (int i = 0; i < NMASTER; i++) begin
            master_resp_o[i].gnt    = push && (sel == IDX_W'(i));
            master_resp_o[i].rvalid = pop && (head_idx == IDX_W'(i));
            master_resp_o[i].rdata  = slave_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            err_o    <= 1'b0;
        end else begin
            lock_vld <= slave_req_o.req & ~slave_resp_i.gnt;
            lock_idx <= sel;
            if (push) rr_ptr <= (sel == IDX_W'(NMASTER - 1)) ? '0 : sel + 1'b1;
            if (slave_resp_i.rvalid && fifo_empty) err_o <= 1'b1;
        end
    end

    obi_mux_idx_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W),
        .CNT_W (CNT_W)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (sel),
        .pop_i   (pop),
        .rdata_o (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    assign busy_o = (outstanding_o != '0) | slave_req_o.req;

`ifdef OBI_MUX_PERF_EN
    for (genvar g = 0; g < NMASTER; g++) begin : g_grant_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)                          grant_cnt_o[g] <= '0;
            else if (push && sel == IDX_W'(g))    grant_cnt_o[g] <= grant_cnt_o[g] + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    stall_cnt_o <= '0;
        else if (fifo_full && |req_vec) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_obi_mux_rr_outstanding.sv
// Directed bench for obi_mux_rr_outstanding: RR and fixed-priority instances, response scoreboard.
module tb_obi_mux_rr_outstanding;
    import obi_pkg::*;
    import obi_mux_pkg::*;

    localparam int NM = 4;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    typedef obi_resp_t [NM-1:0] resp_vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    obi_req_t  [NM-1:0]   mreq;
    resp_vec_t            mresp_rr, mresp_fp;
    obi_req_t             sreq_rr, sreq_fp;
    obi_resp_t            sresp;
    logic      [CW-1:0]   out_rr, out_fp;
    logic                 busy_rr, busy_fp, err_rr, err_fp;
`ifdef OBI_MUX_PERF_EN
    logic [NM-1:0][31:0]  gcnt_rr, gcnt_fp;
    logic [31:0]          scnt_rr, scnt_fp;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    obi_mux_rr_outstanding #(.NMASTER(NM), .MAX_OUTSTANDING(MO), .RR_MODE(ARB_RR)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .master_req_i(mreq), .master_resp_o(mresp_rr),
        .slave_req_o(sreq_rr), .slave_resp_i(sresp), .outstanding_o(out_rr),
        .busy_o(busy_rr), .err_o(err_rr)
`ifdef OBI_MUX_PERF_EN
        , .grant_cnt_o(gcnt_rr), .stall_cnt_o(scnt_rr)
`endif
    );

    obi_mux_rr_outstanding #(.NMASTER(NM), .MAX_OUTSTANDING(MO), .RR_MODE(ARB_FIXED)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .master_req_i(mreq), .master_resp_o(mresp_fp),
        .slave_req_o(sreq_fp), .slave_resp_i(sresp), .outstanding_o(out_fp),
        .busy_o(busy_fp), .err_o(err_fp)
`ifdef OBI_MUX_PERF_EN
        , .grant_cnt_o(gcnt_fp), .stall_cnt_o(scnt_fp)
`endif
    );

    function automatic logic [31:0] gvec(input resp_vec_t r);
        logic [31:0] v = '0;
        for (int i = 0; i < NM; i++) v[i] = r[i].gnt;
        return v;
    endfunction

    function automatic logic [31:0] rvec(input resp_vec_t r);
        logic [31:0] v = '0;
        for (int i = 0; i < NM; i++) v[i] = r[i].rvalid;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [NM-1:0] m);
        for (int i = 0; i < NM; i++) begin
            mreq[i].req   = m[i];
            mreq[i].we    = i[0];
            mreq[i].be    = 4'hf;
            mreq[i].addr  = 32'h1000 * (i + 1);
            mreq[i].wdata = 32'ha0 + i;
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata);
        sresp.gnt    = gnt;
        sresp.rvalid = rv;
        sresp.rdata  = rdata;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expect a grant to master m on the chosen instance and queue its response.
    task automatic exp_gnt(input bit fp, input int m);
        chk("gnt", fp ? gvec(mresp_fp) : gvec(mresp_rr), 32'd1 << m);
        exp_q.push_back(m);
    endtask

    task automatic exp_idle(input bit fp);
        chk("no_gnt", fp ? gvec(mresp_fp) : gvec(mresp_rr), 32'd0);
    endtask

    task automatic exp_rv(input bit fp);
        int m;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rvalid_q: observed empty scoreboard expected entry");
        end else begin
            m = exp_q.pop_front();
            chk("rvalid", fp ? rvec(mresp_fp) : rvec(mresp_rr), 32'd1 << m);
            chk("rdata", fp ? mresp_fp[m].rdata : mresp_rr[m].rdata, sresp.rdata);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        set_req('0);
        drive(1'b1, 1'b0, 32'h0);
        #3;
        chk("rst_out", 32'(out_rr), 32'd0);
        chk("rst_busy", 32'(busy_rr), 32'd0);
        chk("rst_err", 32'(err_rr), 32'd0);
        chk("rst_gnt", gvec(mresp_rr), 32'd0);
        chk("rst_rv", rvec(mresp_rr), 32'd0);
        chk("rst_sreq", 32'(sreq_rr.req), 32'd0);
`ifdef OBI_MUX_PERF_EN
        chk("rst_gcnt", gcnt_rr[1], 32'd0);
        chk("rst_scnt", scnt_rr, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;

        // RR rotation with one-cycle response latency
        for (int k = 0; k < 5; k++) begin
            tick; set_req(4'hf); drive(1'b1, k > 0, 32'hd000 + k); #1;
            if (k > 0) exp_rv(0);
            exp_gnt(0, k % 4);
            chk("rr_out", 32'(out_rr), (k == 0) ? 32'd0 : 32'd1);
            chk("rr_busy", 32'(busy_rr), 32'd1);
        end
        tick; set_req('0); drive(1'b1, 1'b1, 32'hd005); #1;
        exp_rv(0);
        chk("rr_out_tail", 32'(out_rr), 32'd1);
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        chk("rr_out_done", 32'(out_rr), 32'd0);
        chk("rr_busy_done", 32'(busy_rr), 32'd0);

        // fixed priority: master 1 starves master 3
        do_reset;
        for (int k = 0; k < 4; k++) begin
            tick; set_req(4'b1010); drive(1'b1, k > 0, 32'he000 + k); #1;
            if (k > 0) exp_rv(1);
            exp_gnt(1, 1);
        end
        for (int k = 0; k < 2; k++) begin
            tick; set_req(4'b1000); drive(1'b1, 1'b1, 32'he100 + k); #1;
            exp_rv(1);
            exp_gnt(1, 3);
        end
        tick; set_req('0); drive(1'b1, 1'b1, 32'he200); #1;
        exp_rv(1);
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        chk("fp_out_done", 32'(out_fp), 32'd0);

        // outstanding limit with withheld responses
        do_reset;
        tick; set_req(4'hf); drive(1'b1, 1'b0, 32'h0); #1;
        exp_gnt(0, 0); chk("lim_out0", 32'(out_rr), 32'd0);
        tick; #1;
        exp_gnt(0, 1); chk("lim_out1", 32'(out_rr), 32'd1);
        tick; #1;
        exp_idle(0); chk("lim_out2", 32'(out_rr), 32'd2);
        chk("lim_sreq", 32'(sreq_rr.req), 32'd0);
        chk("lim_busy", 32'(busy_rr), 32'd1);
        tick; drive(1'b1, 1'b1, 32'hf000); #1;
        exp_rv(0); exp_idle(0); chk("lim_out3", 32'(out_rr), 32'd2);
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        exp_gnt(0, 2); chk("lim_out4", 32'(out_rr), 32'd1);
        tick; set_req('0); drive(1'b1, 1'b1, 32'hf001); #1;
        exp_rv(0); chk("lim_out5", 32'(out_rr), 32'd2);
        tick; drive(1'b1, 1'b1, 32'hf002); #1;
        exp_rv(0);
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        chk("lim_out_done", 32'(out_rr), 32'd0);
        chk("lim_busy_done", 32'(busy_rr), 32'd0);

        // address-phase lock while the slave withholds gnt
        do_reset;
        for (int k = 0; k < 3; k++) begin
            tick; set_req((k == 0) ? 4'b0100 : 4'b0101); drive(1'b0, 1'b0, 32'h0); #1;
            exp_idle(0);
            chk("lock_addr", sreq_rr.addr, 32'h3000);
            chk("lock_sreq", 32'(sreq_rr.req), 32'd1);
        end
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        exp_gnt(0, 2); chk("lock_addr_gnt", sreq_rr.addr, 32'h3000);
        tick; #1;
        exp_gnt(0, 0); chk("lock_next_addr", sreq_rr.addr, 32'h1000);
        tick; set_req('0); drive(1'b1, 1'b1, 32'hc000); #1;
        exp_rv(0);
        tick; drive(1'b1, 1'b1, 32'hc001); #1;
        exp_rv(0);
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        chk("lock_out_done", 32'(out_rr), 32'd0);

        // stray response sets sticky err_o
        do_reset;
        tick; drive(1'b0, 1'b1, 32'hbad0); #1;
        chk("stray_rv", rvec(mresp_rr), 32'd0);
        chk("stray_err_pre", 32'(err_rr), 32'd0);
        tick; drive(1'b0, 1'b0, 32'h0); #1;
        chk("stray_err", 32'(err_rr), 32'd1);
        tick; tick; tick;
        chk("stray_err_hold", 32'(err_rr), 32'd1);
        chk("stray_out", 32'(out_rr), 32'd0);

`ifdef OBI_MUX_PERF_EN
        // handshake and stall counters
        do_reset;
        for (int k = 0; k < 2; k++) begin
            tick; set_req(4'b0010); drive(1'b1, 1'b0, 32'h0); #1;
            exp_gnt(0, 1);
        end
        for (int k = 0; k < 2; k++) begin
            tick; #1;
            exp_idle(0);
        end
        tick; set_req('0); drive(1'b1, 1'b1, 32'h7000); #1;
        exp_rv(0);
        for (int k = 0; k < 3; k++) begin
            tick; set_req(4'b0010); drive(1'b1, 1'b1, 32'h7100 + k); #1;
            exp_rv(0);
            exp_gnt(0, 1);
        end
        tick; set_req('0); drive(1'b1, 1'b1, 32'h7200); #1;
        exp_rv(0);
        tick; drive(1'b1, 1'b0, 32'h0); #1;
        chk("perf_gcnt1", gcnt_rr[1], 32'd5);
        chk("perf_gcnt0", gcnt_rr[0], 32'd0);
        chk("perf_scnt", scnt_rr, 32'd2);
`endif

        do_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_mux_rr_outstanding.md
Name: obi_mux_rr_outstanding

Overview:
- Parametrised N-to-1 OBI multiplexer that merges external master ports into one slave port. Typical masters are the external core instruction, data and debug ports and the peripheral bridge; the slave is the external subsystem bus.
- Successor to the fixed 4-master variable-latency xbar. Adds selectable arbitration mode, a configurable number of pipelined outstanding transactions with in-order response routing, address-phase locking, and status/error outputs.

Parameters:
- NMASTER, 4, number of master ports (>=1)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (>=1)
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (index 0 highest)
- IDX_W, (NMASTER>1 ? $clog2(NMASTER) : 1), master index width (derived; not overridden)
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- master_req_i  in  NMASTER x obi_req_t  master requests (req, we, be, addr, wdata)
- master_resp_o  out  NMASTER x obi_resp_t  master responses (gnt, rvalid, rdata)
- slave_req_o  out  obi_req_t  merged request
- slave_resp_i  in  obi_resp_t  slave response
- outstanding_o  out  CNT_W  current outstanding-transaction count
- busy_o  out  1  high when outstanding_o != 0 or slave_req_o.req
- err_o  out  1  sticky: an rvalid arrived with no transaction outstanding

Behaviour:
- Reset: tracking FIFO emptied; RR pointer = 0; lock cleared; outstanding_o = 0; err_o = 0; busy_o = 0. All master gnt/rvalid = 0; slave_req_o.req = 0.
- Eligibility: a master is eligible when its req = 1. When the FIFO is full, no master is eligible: slave_req_o.req = 0 and all gnt = 0. A push is blocked while full even if a pop occurs in the same cycle.
- Arbitration (combinational, zero latency):
  - RR_MODE=1: first eligible index starting at the pointer, wrapping at NMASTER-1 -> 0.
  - RR_MODE=0: lowest eligible index.
- Forwarding: slave_req_o carries the selected master's fields. master_resp_o[sel].gnt = slave_resp_i.gnt; all other gnt = 0.
- Lock: if slave_req_o.req=1 and gnt=0, the selected index is registered. It stays selected until its handshake completes, so address-phase signals stay stable per OBI. The lock releases on handshake, or if the locked master drops req (protocol violation; the mux re-arbitrates).
- Handshake (slave req & gnt):
  - sel is pushed into the tracking FIFO, same cycle.
  - RR pointer becomes (sel+1) mod NMASTER. The pointer changes only on a handshake.
- Response: on slave_resp_i.rvalid with FIFO non-empty:
  - pop the head index h;
  - master_resp_o[h].rvalid = 1; all other rvalid = 0;
  - rdata is broadcast to all masters;
  - response latency through the mux = 0 cycles.
- Stray response: rvalid with FIFO empty is dropped and sets err_o (cleared only by reset).
- Simultaneous push and pop when not full: both occur; outstanding_o is unchanged.
- Outstanding count: outstanding_o = FIFO occupancy, 0..MAX_OUTSTANDING.
- Back-to-back: a master may be granted every cycle while occupancy < MAX_OUTSTANDING.
- NMASTER=1: arbitration logic degenerates; FIFO index width stays 1 bit, value 0.
- Reset mid-operation: all state is cleared asynchronously. Responses arriving after reset release for pre-reset transactions count as stray (err_o).

Optional Feature:
- Macro OBI_MUX_PERF_EN.
- Defined: adds output grant_cnt_o (NMASTER x 32) with per-master handshake counters. Counters are reset to 0, increment on each handshake of that master, and wrap at 2^32-1 -> 0. Adds output stall_cnt_o (32), which increments every cycle the FIFO is full while at least one master requests.
- Undefined: both ports and all counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package obi_mux_pkg holds:
  - arbitration mode constants (ARB_FIXED=0, ARB_RR=1);
  - a function computing IDX_W;
  - the PERF counter width constant (32).
- obi_req_t/obi_resp_t remain from obi_pkg.
- One sub-module: obi_mux_idx_fifo, a parametrised-depth/width sync FIFO with push/pop/full/empty/count, holding granted master indices.

Test Plan:
- NMASTER=4, RR, slave gnt always 1, rvalid 1 cycle later; all four masters request continuously -> grants cycle 0,1,2,3,0; each rvalid is routed to the master granted one cycle earlier; outstanding_o stays at 1 in steady state.
- RR_MODE=0, masters 1 and 3 request -> master 1 granted every cycle; master 3 is never granted until master 1 drops req.
- MAX_OUTSTANDING=2, gnt=1, rvalid withheld -> two handshakes (masters 0 then 1); third request sees gnt=0, outstanding_o=2. Then one rvalid pulse -> master 0 rvalid=1, and a grant is possible the following cycle.
- Slave gnt held 0 for 3 cycles while master 2 is selected and master 0 raises req -> selection stays on master 2; master 2 is granted when gnt rises; master 0 is next.
- rvalid pulse with outstanding_o=0 -> no master rvalid; err_o = 1 and stays 1 until rst_ni is asserted low.
- OBI_MUX_PERF_EN defined: 5 handshakes from master 1 and 2 cycles of full-FIFO stall -> grant_cnt_o[1]=5, stall_cnt_o=2; rst_ni low -> both read 0.
